demux_1xn_param: RTL and testbench
==================================

// Module: demux_1xn_param
// PURPOSE
//  Parametrised 1-to-N byte-lane demultiplexer; successor to the fixed 1x2 8-bit demux.
//  Distributes a serial word stream round-robin across N_LANES output lanes.
//  Runs on a single clock and tracks the lane slot internally, so no divided clocks are needed.
//  Adds lane-aligned group output, a valid-only packing mode and a flush to drain partial groups.
// PARAMETERS
//  DATA_W     8  width of one data word / lane
//  N_LANES    2  output lane count; power of two, >= 2
//  ALIGN_OUT  1  1: all lanes update together once per group; 0: each lane updates on its own slot
//  PACK_MODE  0  0: slot advances every cycle (time-slot demux); 1: slot advances only on valid_in
// PORTS
//  clk_4f     in   1                 single clock (input word rate)
//  reset      in   1                 synchronous, active-high reset
//  data_in    in   DATA_W            input word
//  valid_in   in   1                 data_in qualifier
//  flush      in   1                 emit pending partial group, restart at slot 0
//  data_out   out  N_LANES*DATA_W    lane k at bits [k*DATA_W +: DATA_W]
//  valid_out  out  N_LANES           per-lane valid
//  group_stb  out  1                 1-cycle pulse when an aligned group is presented (ALIGN_OUT=1)
//  slot_idx   out  $clog2(N_LANES)   current slot counter s
// BEHAVIOUR
//  - Reset (sync, high): s=0, staging data/valid=0, data_out=0, valid_out=0, group_stb=0.
//    Reset mid-group discards the partial group; no strobe is issued.
//  - Slot counter s (0..N_LANES-1, wraps N_LANES-1 -> 0):
//    * PACK_MODE=0: increments every cycle.
//    * PACK_MODE=1: increments only on valid_in=1.
//  - Capture: at slot s, word k=s latched into stage_d[k]; stage_v[k] <= valid_in.
//    In PACK_MODE=0 an invalid slot still consumes its lane (stage_v[k]=0, stage_d[k] unchanged).
//  - ALIGN_OUT=0: lane s output regs are written directly at the capture edge (latency 1 cycle).
//    * Data and valid are held until that lane's next slot.
//    * Only the lane at slot s changes per cycle; group_stb stays 0.
//  - ALIGN_OUT=1: group completes on the capture edge at s=N_LANES-1.
//    * Completion condition: PACK_MODE=0 any cycle at that slot; PACK_MODE=1 only when valid_in=1.
//    * On that edge, data_out/valid_out <= {current word, stage[N-2:0]} and group_stb=1 for that cycle.
//    * Latency: 1 cycle for the last word, N_LANES cycles for lane 0 (PACK_MODE=0).
//    * Outputs hold between groups.
//  - flush=1 (sampled at the edge):
//    * Pending lanes 0..s-1, plus the current word if valid_in=1, are emitted.
//    * valid_out bits are set only for filled lanes; remaining lanes get valid=0 and data=0.
//    * group_stb=1 and s <= 0.
//    * If s==0 and valid_in=0: no-op, no strobe, outputs held.
//    * With ALIGN_OUT=0, flush only forces s <= 0 (plus a normal capture of the current valid word).
//  - flush at the completing slot behaves as a normal full group; s <= 0.
//  - Staging valid bits are cleared after every group/flush, so lanes never leak into the next group.
//  - All outputs are registered; there is no combinational path from inputs to outputs.
// TESTING (defaults DATA_W=8, N_LANES=2 unless noted)
//  1. P0/A1, valid=1, data A1,B2,C3,D4
//     -> after cycle 2: data_out=16'hB2A1, valid_out=2'b11, group_stb pulse; after cycle 4: 16'hD4C3.
//  2. P0/A1, data A1 valid=0 then B2 valid=1
//     -> valid_out=2'b10, data_out[15:8]=B2, group_stb pulse.
//  3. P1/A1, valid pattern 1,0,0,1 (A1,x,x,B2)
//     -> single group 16'hB2A1, valid_out=2'b11 one cycle after B2; slot_idx holds through gaps.
//  4. N_LANES=4 P1/A1, 3 valid words 11,22,33 then flush
//     -> data_out=32'h00332211, valid_out=4'b0111, group_stb=1, slot_idx=0.
//  5. P0/A0, stream 01,02,03,04
//     -> lane0 updates on odd cycles, lane1 on even, each 1 cycle after input; group_stb stays 0.
//  6. Reset asserted mid-group (after 1 of 2 words)
//     -> all outputs 0 next cycle, slot_idx=0, no group_stb; next two words form a clean group.

Source files
------------

// File: rtl/demux_1xn_param.sv
// Parametrised 1-to-N round-robin word demultiplexer.
// Single clock; optional lane-aligned groups, valid packing and flush.
module demux_1xn_param #(
  parameter int DATA_W    = 8,
  parameter int N_LANES   = 2,
  parameter int ALIGN_OUT = 1,
  parameter int PACK_MODE = 0
) (
  input  logic                        clk_4f,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        valid_in,
  input  logic                        flush,
  output logic [N_LANES*DATA_W-1:0]   data_out,
  output logic [N_LANES-1:0]          valid_out,
  output logic                        group_stb,
  output logic [$clog2(N_LANES)-1:0]  slot_idx
);

  localparam int SW = $clog2(N_LANES);
  localparam logic [SW-1:0] LAST = SW'(N_LANES - 1);

  logic [SW-1:0]                    s_q, s_d;
  logic [N_LANES-1:0][DATA_W-1:0]   stg_dat_q, stg_dat_d;
  logic [N_LANES-1:0]               stg_vld_q, stg_vld_d;
  logic [N_LANES-1:0][DATA_W-1:0]   dat_q, dat_d;
  logic [N_LANES-1:0]               vld_q, vld_d;
  logic                             stb_q, stb_d;

  logic adv;
  logic complete;
  logic fill;

  assign adv      = (PACK_MODE == 0) || valid_in;
  assign complete = (s_q == LAST) && adv;

  always_comb begin
    s_d       = s_q;
    stg_dat_d = stg_dat_q;
    stg_vld_d = stg_vld_q;
    dat_d     = dat_q;
    vld_d     = vld_q;
    stb_d     = 1'b0;
    fill      = 1'b0;
    if (ALIGN_OUT != 0) begin
      if (complete) begin
        for (int k = 0; k < N_LANES-1; k++) begin
          dat_d[k] = stg_dat_q[k];
          vld_d[k] = stg_vld_q[k];
        end
        dat_d[N_LANES-1] = data_in;
        vld_d[N_LANES-1] = valid_in;
        stb_d     = 1'b1;
        stg_vld_d = '0;
        s_d       = '0;
      end else if (flush) begin
        s_d = '0;
        // Nothing pending and nothing arriving: leave outputs alone.
        if (s_q != '0 || valid_in) begin
          for (int k = 0; k < N_LANES; k++) begin
            fill = (SW'(k) < s_q && stg_vld_q[k]) ||
                   (SW'(k) == s_q && valid_in);
            vld_d[k] = fill;
            if (!fill)
              dat_d[k] = '0;
            else if (SW'(k) == s_q)
              dat_d[k] = data_in;
            else
              dat_d[k] = stg_dat_q[k];
          end
          stb_d     = 1'b1;
          stg_vld_d = '0;
        end
      end else if (adv) begin
        stg_vld_d[s_q] = valid_in;
        if (valid_in)
          stg_dat_d[s_q] = data_in;
        s_d = s_q + 1'b1;
      end
    end else begin
      if (adv) begin
        vld_d[s_q] = valid_in;
        if (valid_in)
          dat_d[s_q] = data_in;
        s_d = s_q + 1'b1;
      end
      if (flush)
        s_d = '0;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      s_q       <= '0;
      stg_dat_q <= '0;
      stg_vld_q <= '0;
      dat_q     <= '0;
      vld_q     <= '0;
      stb_q     <= 1'b0;
    end else begin
      s_q       <= s_d;
      stg_dat_q <= stg_dat_d;
      stg_vld_q <= stg_vld_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      stb_q     <= stb_d;
    end
  end

  assign data_out  = dat_q;
  assign valid_out = vld_q;
  assign group_stb = stb_q;
  assign slot_idx  = s_q;

endmodule

// File: tb/tb_demux_1xn_param.sv
// Bench for demux_1xn_param: five configurations share one stimulus
// stream, each checked against a pending-word-list model.
module tb_demux_1xn_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, vin = 1'b0, fl = 1'b0;
  logic [7:0] din = '0;

  logic [15:0] d0, d1, d3;
  logic [31:0] d2, d4;
  logic [1:0]  v0, v1, v3;
  logic [3:0]  v2, v4;
  logic        g0, g1, g2, g3, g4;
  logic [0:0]  s0, s1, s3;
  logic [1:0]  s2, s4;

  demux_1xn_param #(.DATA_W(8), .N_LANES(2), .ALIGN_OUT(1), .PACK_MODE(0)) u0 (
    .clk_4f(clk), .reset(rst), .data_in(din), .valid_in(vin), .flush(fl),
    .data_out(d0), .valid_out(v0), .group_stb(g0), .slot_idx(s0));
  demux_1xn_param #(.DATA_W(8), .N_LANES(2), .ALIGN_OUT(1), .PACK_MODE(1)) u1 (
    .clk_4f(clk), .reset(rst), .data_in(din), .valid_in(vin), .flush(fl),
    .data_out(d1), .valid_out(v1), .group_stb(g1), .slot_idx(s1));
  demux_1xn_param #(.DATA_W(8), .N_LANES(4), .ALIGN_OUT(1), .PACK_MODE(1)) u2 (
    .clk_4f(clk), .reset(rst), .data_in(din), .valid_in(vin), .flush(fl),
    .data_out(d2), .valid_out(v2), .group_stb(g2), .slot_idx(s2));
  demux_1xn_param #(.DATA_W(8), .N_LANES(2), .ALIGN_OUT(0), .PACK_MODE(0)) u3 (
    .clk_4f(clk), .reset(rst), .data_in(din), .valid_in(vin), .flush(fl),
    .data_out(d3), .valid_out(v3), .group_stb(g3), .slot_idx(s3));
  demux_1xn_param #(.DATA_W(8), .N_LANES(4), .ALIGN_OUT(1), .PACK_MODE(0)) u4 (
    .clk_4f(clk), .reset(rst), .data_in(din), .valid_in(vin), .flush(fl),
    .data_out(d4), .valid_out(v4), .group_stb(g4), .slot_idx(s4));

  int NL[5] = '{2, 2, 4, 2, 4};
  int PM[5] = '{0, 1, 1, 0, 0};
  int AO[5] = '{1, 1, 1, 0, 1};

  int         cnt[5];
  bit         pv[5][4];
  logic [7:0] pd[5][4];
  bit         ev[5][4];
  logic [7:0] ed[5][4];
  bit         em[5][4];
  bit         estb[5];

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void emit(int i, int n, bit strict);
    for (int k = 0; k < NL[i]; k++) begin
      if (k < n) begin
        ev[i][k] = pv[i][k];
        ed[i][k] = pv[i][k] ? pd[i][k] : 8'h00;
        em[i][k] = strict | pv[i][k];
      end else begin
        ev[i][k] = 1'b0;
        ed[i][k] = 8'h00;
        em[i][k] = 1'b1;
      end
    end
    estb[i] = 1'b1;
  endfunction

  function automatic void step(int i, bit r, bit v, logic [7:0] d, bit f);
    bit adv;
    if (r) begin
      cnt[i] = 0;
      estb[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        ev[i][k] = 1'b0; ed[i][k] = 8'h00; em[i][k] = 1'b1; pv[i][k] = 1'b0;
      end
      return;
    end
    estb[i] = 1'b0;
    adv = (PM[i] == 0) || v;
    if (AO[i] != 0) begin
      if (adv && cnt[i] == NL[i]-1) begin
        pv[i][cnt[i]] = v; pd[i][cnt[i]] = d;
        emit(i, NL[i], 1'b0);
        cnt[i] = 0;
      end else if (f) begin
        if (v) begin
          pv[i][cnt[i]] = 1'b1; pd[i][cnt[i]] = d; cnt[i]++;
        end
        if (cnt[i] > 0) emit(i, cnt[i], 1'b1);
        cnt[i] = 0;
      end else if (adv) begin
        pv[i][cnt[i]] = v; pd[i][cnt[i]] = d; cnt[i]++;
      end
    end else begin
      if (adv) begin
        ev[i][cnt[i]] = v;
        if (v) ed[i][cnt[i]] = d;
        cnt[i] = (cnt[i] + 1) % NL[i];
      end
      if (f) cnt[i] = 0;
    end
  endfunction

  task automatic check_all();
    logic [63:0] od, ov, os, xd, xv, mk;
    logic og;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin od = 64'(d0); ov = 64'(v0); og = g0; os = 64'(s0); end
        1: begin od = 64'(d1); ov = 64'(v1); og = g1; os = 64'(s1); end
        2: begin od = 64'(d2); ov = 64'(v2); og = g2; os = 64'(s2); end
        3: begin od = 64'(d3); ov = 64'(v3); og = g3; os = 64'(s3); end
        default: begin od = 64'(d4); ov = 64'(v4); og = g4; os = 64'(s4); end
      endcase
      xd = '0; xv = '0; mk = '0;
      for (int k = 0; k < NL[i]; k++) begin
        xd[k*8 +: 8] = ed[i][k];
        xv[k]        = ev[i][k];
        mk[k*8 +: 8] = em[i][k] ? 8'hFF : 8'h00;
      end
      chk($sformatf("data%0d", i), od & mk, xd & mk);
      chk($sformatf("valid%0d", i), ov, xv);
      chk($sformatf("stb%0d", i), 64'(og), 64'(estb[i]));
      chk($sformatf("slot%0d", i), os, 64'(cnt[i]));
    end
  endtask

  task automatic drive(bit r, bit v, logic [7:0] d, bit f);
    rst = r; vin = v; din = d; fl = f;
    @(posedge clk);
    for (int i = 0; i < 5; i++) step(i, r, v, d, f);
    #1;
    check_all();
  endtask

  initial begin
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    chk("rst_data", 64'(d0), 64'h0);
    chk("rst_stb", 64'(g2), 64'h0);

    drive(0, 1, 8'hA1, 0);
    drive(0, 1, 8'hB2, 0);
    chk("t1_g1", 64'(d0), 64'hB2A1);
    chk("t1_v1", 64'(v0), 64'h3);
    chk("t1_s1", 64'(g0), 64'h1);
    drive(0, 1, 8'hC3, 0);
    drive(0, 1, 8'hD4, 0);
    chk("t1_g2", 64'(d0), 64'hD4C3);

    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'hA1, 0);
    drive(0, 1, 8'hB2, 0);
    chk("t2_v", 64'(v0), 64'h2);
    chk("t2_d", 64'(d0[15:8]), 64'hB2);
    chk("t2_s", 64'(g0), 64'h1);

    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'hA1, 0);
    drive(0, 0, 8'h5A, 0);
    drive(0, 0, 8'h6B, 0);
    chk("t3_hold", 64'(s1), 64'h1);
    drive(0, 1, 8'hB2, 0);
    chk("t3_d", 64'(d1), 64'hB2A1);
    chk("t3_v", 64'(v1), 64'h3);

    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h11, 0);
    drive(0, 1, 8'h22, 0);
    drive(0, 1, 8'h33, 0);
    drive(0, 0, 8'h00, 1);
    chk("t4_d", 64'(d2), 64'h00332211);
    chk("t4_v", 64'(v2), 64'h7);
    chk("t4_s", 64'(g2), 64'h1);
    chk("t4_slot", 64'(s2), 64'h0);

    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h01, 0);
    chk("t5_l0", 64'(d3), 64'h0001);
    drive(0, 1, 8'h02, 0);
    drive(0, 1, 8'h03, 0);
    drive(0, 1, 8'h04, 0);
    chk("t5_d", 64'(d3), 64'h0403);
    chk("t5_s", 64'(g3), 64'h0);

    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h77, 0);
    drive(1, 1, 8'h88, 0);
    chk("t6_d", 64'(d0), 64'h0);
    chk("t6_slot", 64'(s0), 64'h0);
    chk("t6_s", 64'(g0), 64'h0);
    drive(0, 1, 8'h55, 0);
    drive(0, 1, 8'h66, 0);
    chk("t6_g", 64'(d0), 64'h6655);

    for (int c = 0; c < 2000; c++)
      drive($urandom_range(63) == 0, $urandom_range(9) < 6,
            8'($urandom), $urandom_range(7) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
